// File: rtl/mult_eval_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_eval_pkg
//  Brief    : Shared types and constants for the approximate-multiplier
//             error-statistics stage.
//  Revision : 1.0 - initial release
// ============================================================================
package mult_eval_pkg;

    localparam int OP_W          = 32;
    localparam int PROD_W        = 64;
    localparam int SUM_W_DEFAULT = 96;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_err_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_err_monitor_if
//  Brief    : Control, sample-stream and statistics bundle of the error
//             monitor. The harness drives it as master, the monitor is slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface mult_err_monitor_if
    import mult_eval_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEFAULT
);
    logic              start;
    logic [31:0]       n_samples;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [PROD_W-1:0] p_approx;
    logic              busy;
    logic              done;
    logic [31:0]       sample_cnt;
    logic [31:0]       err_cnt;
    logic [SUM_W-1:0]  sum_ed;
    logic [PROD_W-1:0] max_ed;
    logic              sum_sat;

    modport master (
        output start, n_samples, in_valid, a, b, p_approx,
        input  in_ready, busy, done, sample_cnt, err_cnt, sum_ed, max_ed, sum_sat
    );

    modport slave (
        input  start, n_samples, in_valid, a, b, p_approx,
        output in_ready, busy, done, sample_cnt, err_cnt, sum_ed, max_ed, sum_sat
    );
endinterface
`default_nettype wire

// File: rtl/mult_err_dist.sv
`default_nettype none
// ============================================================================
//  Module   : mult_err_dist
//  Brief    : Exact-product and absolute error-distance stage. Registered
//             output so a multi-cycle exact multiplier can drop in later.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_err_dist
    import mult_eval_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              in_valid,
    input  wire logic [OP_W-1:0]   a,
    input  wire logic [OP_W-1:0]   b,
    input  wire logic [PROD_W-1:0] p_approx,
    output logic                   out_valid,
    output logic [PROD_W-1:0]      ed,
    output logic                   ed_nz
);
    logic [PROD_W-1:0] w_exact;
    logic [PROD_W:0]   w_diff;
    logic [PROD_W-1:0] w_ed;

    // Exact product and 65-bit difference; the magnitude always fits 64 bits,
    // so negating only the low 64 bits of a negative difference is exact.
    always_comb begin
        w_exact = PROD_W'(a) * PROD_W'(b);
        w_diff  = {1'b0, w_exact} - {1'b0, p_approx};
        w_ed    = w_diff[PROD_W] ? (~w_diff[PROD_W-1:0] + 64'd1) : w_diff[PROD_W-1:0];
    end

    // S2 register: ED, nonzero flag and valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            ed        <= '0;
            ed_nz     <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ed    <= w_ed;
                ed_nz <= |w_ed;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/mult_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : mult_err_monitor
//  Brief    : Batch error-statistics monitor for approximate multipliers:
//             sample count, error count, saturating ED sum and max ED.
//  Revision : 1.0 - initial release
// ============================================================================
module mult_err_monitor
    import mult_eval_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEFAULT
)(
    input  wire logic         clk,
    input  wire logic         rst,
    mult_err_monitor_if.slave bus
);
    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_n_lat;
    logic [31:0]       r_issue;
    logic              r_v1;
    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;
    logic [PROD_W-1:0] r_p;
    logic [31:0]       r_sample_cnt;
    logic [31:0]       r_err_cnt;
    logic [SUM_W-1:0]  r_sum_ed;
    logic [PROD_W-1:0] r_max_ed;
    logic              r_sum_sat;

    logic              w_v2;
    logic [PROD_W-1:0] w_ed;
    logic              w_ed_nz;
    logic              w_busy;
    logic              w_done;
    logic              w_in_ready;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_last;
    logic [SUM_W:0]    w_sum_ext;

    assign w_start_ok = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = w_accept && ((r_issue + 32'd1) == r_n_lat);
    assign w_sum_ext  = {1'b0, r_sum_ed} + {{(SUM_W + 1 - PROD_W){1'b0}}, w_ed};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; DRAIN waits until both pipeline stages are empty.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: if (bus.start) w_next_state = (bus.n_samples == 32'd0) ? DONE : RUN;
            RUN:        if (w_last) w_next_state = DRAIN;
            DRAIN:      if (!r_v1 && !w_v2) w_next_state = DONE;
            default:    w_next_state = IDLE;
        endcase
    end

    // State-decoded outputs; in_ready never looks at in_valid.
    always_comb begin
        w_busy     = 1'b0;
        w_done     = 1'b0;
        w_in_ready = 1'b0;
        case (r_state)
            RUN: begin
                w_busy     = 1'b1;
                w_in_ready = (r_issue < r_n_lat);
            end
            DRAIN:   w_busy = 1'b1;
            DONE:    w_done = 1'b1;
            default: ;
        endcase
    end

    // Batch length latch, issue counter and S1 capture register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n_lat <= '0;
            r_issue <= '0;
            r_v1    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
        end else begin
            r_v1 <= w_accept;
            if (w_start_ok) begin
                r_n_lat <= bus.n_samples;
                r_issue <= '0;
            end else if (w_accept) begin
                r_issue <= r_issue + 32'd1;
            end
            if (w_accept) begin
                r_a <= bus.a;
                r_b <= bus.b;
                r_p <= bus.p_approx;
            end
        end
    end

    mult_err_dist u_err_dist (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_v1),
        .a         (r_a),
        .b         (r_b),
        .p_approx  (r_p),
        .out_valid (w_v2),
        .ed        (w_ed),
        .ed_nz     (w_ed_nz)
    );

    // Statistics accumulation; a carry out of the sum clamps it to all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_sum_ed     <= '0;
            r_max_ed     <= '0;
            r_sum_sat    <= 1'b0;
        end else if (w_start_ok) begin
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_sum_ed     <= '0;
            r_max_ed     <= '0;
            r_sum_sat    <= 1'b0;
        end else if (w_v2) begin
            r_sample_cnt <= r_sample_cnt + 32'd1;
            if (w_ed_nz) r_err_cnt <= r_err_cnt + 32'd1;
            if (w_sum_ext[SUM_W]) begin
                r_sum_ed  <= '1;
                r_sum_sat <= 1'b1;
            end else begin
                r_sum_ed  <= w_sum_ext[SUM_W-1:0];
            end
            if (w_ed > r_max_ed) r_max_ed <= w_ed;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.sample_cnt = r_sample_cnt;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.sum_ed     = r_sum_ed;
    assign bus.max_ed     = r_max_ed;
    assign bus.sum_sat    = r_sum_sat;
endmodule
`default_nettype wire

// File: tb/tb_mult_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_err_monitor
//  Brief    : Directed self-checking bench for mult_err_monitor (96-bit sum
//             instance plus a 64-bit sum instance for saturation).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_err_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mult_err_monitor_if #(.SUM_W(96)) bus   ();
    mult_err_monitor_if #(.SUM_W(64)) bus64 ();

    mult_err_monitor #(.SUM_W(96)) dut   (.clk(clk), .rst(rst), .bus(bus));
    mult_err_monitor #(.SUM_W(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] n);
        bus.start     = 1'b1;
        bus.n_samples = n;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic drive_sample(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.p_approx = p;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.n_samples = 0; bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.p_approx = 0;
        bus64.start = 0; bus64.n_samples = 0; bus64.in_valid = 0; bus64.a = 0; bus64.b = 0; bus64.p_approx = 0;
        rst = 1'b1;
        tick(); tick();
        total++; if ({bus.busy, bus.done, bus.in_ready, bus.sum_sat} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.busy, bus.done, bus.in_ready, bus.sum_sat}); end
        total++; if (bus.sample_cnt !== 32'd0 || bus.err_cnt !== 32'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.sample_cnt, bus.err_cnt); end
        total++; if (bus.sum_ed !== 96'd0 || bus.max_ed !== 64'd0) begin bad++; $display("FAIL reset_sums got=%h/%h exp=0/0", bus.sum_ed, bus.max_ed); end
        rst = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL reset_idle got busy=%b done=%b exp=0/0", bus.busy, bus.done); end
    endtask

    task automatic test_single_exact();
        pulse_start(32'd1);
        total++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_start got busy=%b rdy=%b exp=1/1", bus.busy, bus.in_ready); end
        drive_sample(32'd3, 32'd5, 64'd15);
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL single_drain got rdy=%b busy=%b exp=0/1", bus.in_ready, bus.busy); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL single_done_t1 got=%b exp=0", bus.done); end
        tick();
        total++; if (bus.done !== 1'b0 || bus.sample_cnt !== 32'd1) begin bad++; $display("FAIL single_t2 got done=%b cnt=%0d exp=0/1", bus.done, bus.sample_cnt); end
        tick();
        total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_done_t3 got done=%b busy=%b exp=1/0", bus.done, bus.busy); end
        total++; if (bus.sample_cnt !== 32'd1 || bus.err_cnt !== 32'd0 || bus.sum_ed !== 96'd0 || bus.max_ed !== 64'd0)
            begin bad++; $display("FAIL single_stats got cnt=%0d err=%0d sum=%h max=%h exp=1/0/0/0", bus.sample_cnt, bus.err_cnt, bus.sum_ed, bus.max_ed); end
    endtask

    task automatic test_worst_case();
        pulse_start(32'd2);
        drive_sample(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
        tick();
        drive_sample(32'd2, 32'd2, 64'd5);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && bus.done !== 1'b1; i++) tick();
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL worst_timeout got done=%b exp=1", bus.done); end
        total++; if (bus.sample_cnt !== 32'd2 || bus.err_cnt !== 32'd2) begin bad++; $display("FAIL worst_counts got=%0d/%0d exp=2/2", bus.sample_cnt, bus.err_cnt); end
        total++; if (bus.max_ed !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL worst_max got=%h exp=fffffffe00000001", bus.max_ed); end
        total++; if (bus.sum_ed !== 96'h0000_0000_FFFF_FFFE_0000_0002 || bus.sum_sat !== 1'b0)
            begin bad++; $display("FAIL worst_sum got=%h sat=%b exp=fffffffe00000002/0", bus.sum_ed, bus.sum_sat); end
    endtask

    task automatic test_empty();
        pulse_start(32'd0);
        total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0)
            begin bad++; $display("FAIL empty_state got done=%b busy=%b rdy=%b exp=1/0/0", bus.done, bus.busy, bus.in_ready); end
        drive_sample(32'd9, 32'd9, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL empty_ready cycle=%0d got=%b exp=0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        total++; if (bus.sample_cnt !== 32'd0 || bus.err_cnt !== 32'd0 || bus.sum_ed !== 96'd0 || bus.max_ed !== 64'd0)
            begin bad++; $display("FAIL empty_stats got cnt=%0d err=%0d sum=%h max=%h exp=0", bus.sample_cnt, bus.err_cnt, bus.sum_ed, bus.max_ed); end
    endtask

    task automatic test_boundary();
        logic [31:0] va [5] = '{32'd1, 32'd2, 32'd4, 32'd5, 32'd6};
        logic [31:0] vb [5] = '{32'd1, 32'd3, 32'd4, 32'd5, 32'd6};
        logic [63:0] vp [5] = '{64'd1, 64'd7, 64'd10, 64'd0, 64'd0};
        pulse_start(32'd3);
        for (int k = 0; k < 5; k++) begin
            drive_sample(va[k], vb[k], vp[k]);
            if (k == 3) begin bus.start = 1'b1; bus.n_samples = 32'd7; end
            tick();
            bus.start = 1'b0;
            total++; if (bus.in_ready !== (k < 2)) begin bad++; $display("FAIL boundary_ready k=%0d got=%b exp=%b", k, bus.in_ready, (k < 2)); end
        end
        bus.in_valid = 1'b0;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL boundary_busy got=%b exp=1", bus.busy); end
        tick();
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL boundary_done got=%b exp=1", bus.done); end
        total++; if (bus.sample_cnt !== 32'd3 || bus.err_cnt !== 32'd2 || bus.sum_ed !== 96'd7 || bus.max_ed !== 64'd6)
            begin bad++; $display("FAIL boundary_stats got cnt=%0d err=%0d sum=%0d max=%0d exp=3/2/7/6", bus.sample_cnt, bus.err_cnt, bus.sum_ed, bus.max_ed); end
        tick();
        total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("FAIL boundary_hold got done=%b busy=%b exp=1/0", bus.done, bus.busy); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start(32'd4);
        drive_sample(32'd10, 32'd10, 64'd90); tick();
        drive_sample(32'd3,  32'd3,  64'd9);  tick();
        drive_sample(32'd1,  32'd2,  64'd5);  tick();
        bus.in_valid = 1'b0;
        total++; if (bus.sample_cnt !== 32'd1 || bus.max_ed !== 64'd10) begin bad++; $display("FAIL midrun_pre got cnt=%0d max=%0d exp=1/10", bus.sample_cnt, bus.max_ed); end
        #2 rst = 1'b1;
        #1;
        total++; if ({bus.busy, bus.done, bus.in_ready, bus.sum_sat} !== 4'b0) begin bad++; $display("FAIL midrun_flags got=%b exp=0000", {bus.busy, bus.done, bus.in_ready, bus.sum_sat}); end
        total++; if (bus.sample_cnt !== 32'd0 || bus.err_cnt !== 32'd0 || bus.sum_ed !== 96'd0 || bus.max_ed !== 64'd0)
            begin bad++; $display("FAIL midrun_stats got cnt=%0d err=%0d sum=%h max=%h exp=0", bus.sample_cnt, bus.err_cnt, bus.sum_ed, bus.max_ed); end
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        total++; if (bus.sample_cnt !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
            begin bad++; $display("FAIL midrun_flush got cnt=%0d busy=%b done=%b exp=0/0/0", bus.sample_cnt, bus.busy, bus.done); end
        pulse_start(32'd1);
        drive_sample(32'd7, 32'd8, 64'd50);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && bus.done !== 1'b1; i++) tick();
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL midrun_restart_timeout got done=%b exp=1", bus.done); end
        total++; if (bus.sample_cnt !== 32'd1 || bus.err_cnt !== 32'd1 || bus.sum_ed !== 96'd6 || bus.max_ed !== 64'd6)
            begin bad++; $display("FAIL midrun_restart got cnt=%0d err=%0d sum=%0d max=%0d exp=1/1/6/6", bus.sample_cnt, bus.err_cnt, bus.sum_ed, bus.max_ed); end
    endtask

    task automatic test_saturation();
        bus64.start = 1'b1; bus64.n_samples = 32'd2;
        tick();
        bus64.start = 1'b0;
        bus64.in_valid = 1'b1; bus64.a = 32'hFFFF_FFFF; bus64.b = 32'hFFFF_FFFF; bus64.p_approx = 64'd0;
        tick(); tick();
        bus64.in_valid = 1'b0;
        for (int i = 0; i < 10 && bus64.done !== 1'b1; i++) tick();
        total++; if (bus64.done !== 1'b1) begin bad++; $display("FAIL sat_timeout got done=%b exp=1", bus64.done); end
        total++; if (bus64.sum_ed !== 64'hFFFF_FFFF_FFFF_FFFF || bus64.sum_sat !== 1'b1)
            begin bad++; $display("FAIL sat_sum got=%h sat=%b exp=ffffffffffffffff/1", bus64.sum_ed, bus64.sum_sat); end
        total++; if (bus64.max_ed !== 64'hFFFF_FFFE_0000_0001 || bus64.err_cnt !== 32'd2)
            begin bad++; $display("FAIL sat_max got=%h err=%0d exp=fffffffe00000001/2", bus64.max_ed, bus64.err_cnt); end
        tick(); tick(); tick();
        total++; if (bus64.sum_sat !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b exp=1", bus64.sum_sat); end
        bus64.start = 1'b1; bus64.n_samples = 32'd0;
        tick();
        bus64.start = 1'b0;
        total++; if (bus64.sum_sat !== 1'b0 || bus64.sum_ed !== 64'd0) begin bad++; $display("FAIL sat_clear got sat=%b sum=%h exp=0/0", bus64.sum_sat, bus64.sum_ed); end
    endtask

    initial begin
        test_reset();
        test_single_exact();
        test_worst_case();
        test_empty();
        test_boundary();
        test_reset_mid_run();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mult_err_monitor.md
# mult_err_monitor

Sequential error-statistics stage that sits directly downstream of the 32-bit approximate multipliers generated by the NSGA-II flow. It accepts operand pairs and the approximate product the multiplier under test produced for them, then computes the exact product and the absolute error distance (ED). It accumulates sample count, erroneous-sample count, ED sum and maximum ED over a programmed batch. The evaluation harness reads these statistics to score each candidate netlist.

## Interface
- `SUM_W`, default 96: width of the ED-sum accumulator, legal range 64..96. The sum saturates at all-ones.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; loads `n_samples`, clears statistics, begins a batch. Ignored while `busy`.
- `n_samples`  in  32  batch length, sampled only on an accepted `start`.
- `in_valid`  in  1  `a`, `b`, `p_approx` are valid.
- `in_ready`  out  1  the block will accept a sample this cycle.
- `a`, `b`  in  32 each  operands presented to the multiplier under test.
- `p_approx`  in  64  the multiplier's combinational product of `a` and `b`, in the same cycle.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE; statistics are stable.
- `sample_cnt`  out  32  number of samples accumulated.
- `err_cnt`  out  32  number of samples with ED ≠ 0.
- `sum_ed`  out  SUM_W  saturating sum of ED.
- `max_ed`  out  64  largest ED seen in the batch.
- `sum_sat`  out  1  sticky; set when `sum_ed` saturated.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE. Reset enters IDLE. Every output and register resets to 0.
- **IDLE or DONE, `start`=1:**
  - latch `n_samples`;
  - clear all statistics, the issue counter and `sum_sat`;
  - go to RUN. If `n_samples`=0, go to DONE instead.
- **RUN:**
  - `in_ready` = (issue counter < latched `n_samples`).
  - A sample is accepted when `in_valid && in_ready`; the issue counter increments on each accept.
  - When an accept brings the issue counter to `n_samples`, go to DRAIN.
- **DRAIN:** `in_ready`=0. Go to DONE on the first edge at which both pipeline valid bits are 0.
- **DONE:** `done`=1. Statistics hold until the next accepted `start`.
- **Pipeline:**
  - S1 registers `a`, `b`, `p_approx` and valid bit v1.
  - S2 computes exact = a×b (64-bit, unsigned) and ED = |exact − p_approx| using a 65-bit signed difference. The result is always 64 bits, and ED=0 is flagged. S2 registers ED with valid bit v2.
  - The accumulate stage acts on v2:
    - `sample_cnt`+1;
    - `err_cnt`+1 if ED≠0;
    - `sum_ed` += ED, zero-extended, clamped to 2^SUM_W−1, with `sum_sat` set on clamp;
    - `max_ed` = max(`max_ed`, ED).
- **Edge cases:**
  - `start` during RUN or DRAIN is ignored. It never flushes data in flight.
  - `in_valid` while `in_ready`=0: the sample is not taken. The upstream source must hold it.
  - Reset mid-batch returns to IDLE immediately and discards the pipeline.

## Timing
- A sample accepted at edge t is in S1 at t, in S2 at t+1, and reflected in the statistics after edge t+2.
- For the final sample accepted at edge t, `done` rises at edge t+3.
- `start` at edge s: `busy` is high from s. For `n_samples`=0, `done` is high from s.
- Sustained throughput: 1 sample per cycle. There is no internal back-pressure other than batch exhaustion.
- `in_ready` is a registered-state function and does not depend combinationally on `in_valid`.

## Structure
- **Shared package `mult_eval_pkg`:**
  - state enum `{IDLE, RUN, DRAIN, DONE}`;
  - constants `OP_W=32` and `PROD_W=64`;
  - default `SUM_W`.
- **Sub-module `mult_err_dist`:** the S2 datapath. It takes a, b, p_approx and returns a registered ED plus an ED-nonzero flag. It is pipelined so that a future multi-cycle exact multiplier can replace it.

## Test plan
- **Reset mid-RUN:** assert `rst` with 2 samples in flight → all outputs 0, state IDLE, `in_ready`=0. A later `start` with `n_samples`=1 runs normally.
- **Single exact sample:** `n_samples`=1; a=3, b=5, p_approx=15 → `done` 3 edges after accept; `sample_cnt`=1, `err_cnt`=0, `sum_ed`=0, `max_ed`=0.
- **Worst-case error:**
  - `n_samples`=2; sample (0xFFFFFFFF, 0xFFFFFFFF, 0), then sample (2, 2, 5).
  - Required: `err_cnt`=2, `max_ed`=0xFFFFFFFE00000001, `sum_ed`=0xFFFFFFFE00000002.
- **Empty batch:** `n_samples`=0 → `done`=1 immediately, `in_ready` never high, all counts 0.
- **Batch boundary:** `n_samples`=3, `in_valid` held high over 5 distinct vectors → exactly the first 3 accepted; `in_ready` low from the edge after the third accept. `start` pulsed in DRAIN is ignored.
- **Saturation:** SUM_W=64; two samples with ED=0xFFFFFFFE00000001 → `sum_ed`=0xFFFFFFFFFFFFFFFF, `sum_sat`=1. `sum_sat` stays 1 until the next `start`.
